// File: rtl/pong_ps2_pkg.sv
// Shared PS/2 constants and frame FSM state type
// for the pong keyboard front end.
package pong_ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_S  = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchroniser, clock filter and 11-bit frame receiver
// with inter-edge timeout.
module ps2_rx_frame
  import pong_ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 65_000_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TW    = $clog2(LIMIT + 1);
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TMAX = TW'(LIMIT - 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;

  frame_state_e  state, state_n;
  logic [7:0]    sh, sh_n;
  logic [2:0]    bcnt, bcnt_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // filt follows clk_s only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FMAX) begin
      filt <= clk_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign fall = filt && !clk_s && (fcnt == FMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      bcnt  <= '0;
      par   <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bcnt  <= bcnt_n;
      par   <= par_n;
      tcnt  <= tcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    bcnt_n   = bcnt;
    par_n    = par;
    tcnt_n   = tcnt;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (fall) begin
      tcnt_n = '0;
      unique case (state)
        IDLE: begin
          if (!data_s) begin
            state_n = DATA;
            bcnt_n  = '0;
          end
        end
        DATA: begin
          sh_n   = {data_s, sh[7:1]};
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_s && (^{sh, par})) rx_valid = 1'b1;
          else rx_err = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tcnt == TMAX) begin
        rx_err  = 1'b1;
        state_n = IDLE;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
  end

  assign rx_byte = sh;

endmodule

// File: rtl/ps2_paddle_decoder.sv
// PS/2 keyboard front end: make/break/extended tracking
// driving level-held up/down paddle requests.
module ps2_paddle_decoder
  import pong_ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 65_000_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [7:0]  KEY_UP     = SC_W,
  parameter logic [7:0]  KEY_DOWN   = SC_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext;
  logic       brk;

  ps2_rx_frame #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  // prefixes persist across frame errors until a non-prefix code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up             <= 1'b0;
      down           <= 1'b0;
      scancode       <= '0;
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
      ext            <= 1'b0;
      brk            <= 1'b0;
    end else begin
      scancode_valid <= rx_valid;
      frame_err      <= rx_err;
      if (rx_valid) begin
        scancode <= rx_byte;
        unique case (1'b1)
          (rx_byte == SC_E0): ext <= 1'b1;
          (rx_byte == SC_F0): brk <= 1'b1;
          default: begin
            if (!ext && rx_byte == KEY_UP)   up   <= !brk;
            if (!ext && rx_byte == KEY_DOWN) down <= !brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_paddle_decoder.sv
// Bench for ps2_paddle_decoder: directed PS/2 frames against
// a byte-level key-state model.
`timescale 1ns/1ps
module tb_ps2_paddle_decoder;

  localparam real H = 2000.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up;
  logic       down;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int err_pend = 0;
  logic [7:0] exp_q[$];
  bit m_up = 0, m_down = 0, m_ext = 0, m_brk = 0;
  realtime t_fall = 0, t_err = 0;

  ps2_paddle_decoder #(.TIMEOUT_US(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .up            (up),
    .down          (down),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .frame_err     (frame_err)
  );

  always #7.692 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $realtime);
    end
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext && b == 8'h1D) m_up = !m_brk;
      if (!m_ext && b == 8'h1B) m_down = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (scancode_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          logic [7:0] b;
          b = exp_q.pop_front();
          chk("scancode", scancode, b);
          m_apply(b);
        end
      end
      if (frame_err) begin
        n_ferr++;
        t_err = $realtime;
        chk("unexpected_err", (err_pend == 0), 0);
        if (err_pend > 0) err_pend--;
      end
      chk("up", up, m_up);
      chk("down", down, m_down);
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #(H);
    ps2_clk = 1'b0;
    t_fall = $realtime;
    #(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input bit flip);
    if (flip) err_pend++;
    else exp_q.push_back(d);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip);
    ps2_bit(1'b1);
    #(2*H);
  endtask

  initial begin
    int v0, e0;
    real dt;
    #100;
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    chk("rst_code", scancode, 0);
    chk("rst_valid", scancode_valid, 0);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    #(4*H);

    send(8'h1D, 0);
    chk("w_code", scancode, 8'h1D);
    chk("w_up", up, 1);
    chk("w_nvalid", n_valid, 1);
    send(8'hF0, 0);
    send(8'h1D, 0);
    chk("wbrk_up", up, 0);
    chk("wbrk_nvalid", n_valid, 3);
    chk("wbrk_noerr", n_ferr, 0);

    send(8'h1B, 0);
    send(8'h1D, 0);
    chk("both_up", up, 1);
    chk("both_down", down, 1);
    send(8'hF0, 0);
    send(8'h1B, 0);
    chk("sbrk_down", down, 0);
    chk("sbrk_up", up, 1);

    send(8'hF0, 0);
    send(8'h1D, 0);
    send(8'hE0, 0);
    send(8'h1D, 0);
    chk("ext_up", up, 0);
    send(8'h1D, 0);
    chk("ext_clr_up", up, 1);

    v0 = n_valid;
    e0 = n_ferr;
    send(8'h1D, 1);
    chk("par_err", n_ferr, e0 + 1);
    chk("par_novalid", n_valid, v0);
    chk("par_up", up, 1);

    e0 = n_ferr;
    err_pend++;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    #30000;
    chk("to_err", n_ferr, e0 + 1);
    dt = t_err - t_fall;
    chk("to_timing", (dt > 19900.0 && dt < 20600.0), 1);
    send(8'h1B, 0);
    chk("to_down", down, 1);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_up", up, 0);
    chk("arst_down", down, 0);
    chk("arst_code", scancode, 0);
    chk("arst_valid", scancode_valid, 0);
    chk("arst_err", frame_err, 0);
    m_up = 0; m_down = 0; m_ext = 0; m_brk = 0;
    exp_q.delete();
    err_pend = 0;
    #100;
    rst_n = 1'b1;
    #(2*H);

    v0 = n_valid;
    e0 = n_ferr;
    ps2_clk = 1'b0;
    #20;
    ps2_clk = 1'b1;
    #(4*H);
    chk("glitch_novalid", n_valid, v0);
    chk("glitch_noerr", n_ferr, e0);
    send(8'h1D, 0);
    chk("post_rst_up", up, 1);
    chk("post_rst_code", scancode, 8'h1D);

    chk("q_drained", exp_q.size(), 0);
    chk("err_drained", err_pend, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
